lf_read_avg: RTL and testbench



---
 rtl/lf_read_avg_if.sv | 9 +
 rtl/lf_read_avg.sv | 120 ++++++++++++
 tb/tb_lf_read_avg.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lf_read_avg_if.sv
// SSP link from the LF read path to the ARM: bit clock, frame strobe and serial data.
interface lf_read_avg_if;
  logic ssp_clk;
  logic ssp_frame;
  logic ssp_din;

  modport master (output ssp_clk, output ssp_frame, output ssp_din);
  modport slave  (input  ssp_clk, input  ssp_frame, input  ssp_din);
endinterface

// File: rtl/lf_read_avg.sv
// LF read path: programmable carrier, phased ADC capture, 2^k averaging and
// MSB-first SSP serialisation with overrun detection.
module lf_read_avg #(
  parameter int unsigned ADC_W        = 8,
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned AVG_MAX_LOG2 = 3
) (
  input  logic              pck0,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  divisor,
  input  logic [DIV_W-1:0]  sample_phase,
  input  logic [1:0]        avg_log2,
  input  logic              carrier_en,
  input  logic              overrun_clr,
  input  logic [ADC_W-1:0]  adc_d,
  output logic              adc_clk,
  output logic              pwr_lo,
  output logic              overrun,
  output logic              dbg,
  lf_read_avg_if.master     ssp
);

  localparam int unsigned ACC_W     = ADC_W + AVG_MAX_LOG2;
  localparam int unsigned CNT_W     = (AVG_MAX_LOG2 > 0) ? AVG_MAX_LOG2 : 1;
  localparam int unsigned BIT_W     = $clog2(ADC_W + 1);
  localparam int unsigned K_MAX     = (AVG_MAX_LOG2 > 3) ? 3 : AVG_MAX_LOG2;
  localparam int unsigned DIV_RST   = 95;
  localparam int unsigned PHASE_RST = 7;

  logic [DIV_W-1:0] pck_divider;
  logic             ant_lo;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       k_q;
  logic [ADC_W-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;

  logic [DIV_W-1:0] eff_phase;
  logic             sample;
  logic [1:0]       avg_k;
  logic [1:0]       k_sel;
  logic [ACC_W-1:0] sum;
  logic             last;
  logic             result_valid;
  logic [ADC_W-1:0] result;
  logic             busy;
  logic             wrap;

  // Sample-point detection and averaging arithmetic; a new window takes its k from avg_log2.
  always_comb begin
    eff_phase    = (phase_q > div_q) ? div_q : phase_q;
    wrap         = (pck_divider == div_q);
    sample       = !ant_lo && (pck_divider == eff_phase);
    avg_k        = (avg_log2 > 2'(K_MAX)) ? 2'(K_MAX) : avg_log2;
    k_sel        = (cnt == '0) ? avg_k : k_q;
    sum          = acc + ACC_W'(adc_d);
    last         = (cnt == CNT_W'((32'd1 << k_sel) - 32'd1));
    result_valid = sample && last;
    result       = ADC_W'(sum >> k_sel);
    busy         = (bit_cnt != '0);
  end

  always_ff @(posedge pck0 or negedge rst_n) begin
    if (!rst_n) begin
      pck_divider <= '0;
      ant_lo      <= 1'b0;
      div_q       <= DIV_W'(DIV_RST);
      phase_q     <= DIV_W'(PHASE_RST);
      acc         <= '0;
      cnt         <= '0;
      k_q         <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      overrun     <= 1'b0;
    end else begin
      // Divisor and phase are only picked up at a wrap so half-periods never glitch.
      if (wrap) begin
        pck_divider <= '0;
        ant_lo      <= ~ant_lo;
        div_q       <= divisor;
        phase_q     <= sample_phase;
      end else begin
        pck_divider <= pck_divider + DIV_W'(1);
      end

      if (sample) begin
        if (cnt == '0) k_q <= avg_k;
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end

      // A result arriving mid-word is dropped so the word in flight completes intact.
      if (result_valid && !busy) begin
        shreg   <= result;
        bit_cnt <= BIT_W'(ADC_W);
      end else if (busy) begin
        shreg   <= {shreg[ADC_W-2:0], 1'b0};
        bit_cnt <= bit_cnt - BIT_W'(1);
      end

      if (result_valid && busy) overrun <= 1'b1;
      else if (overrun_clr)     overrun <= 1'b0;
    end
  end

  assign adc_clk       = ~ant_lo;
  assign dbg           = ~ant_lo;
  assign pwr_lo        = ant_lo & carrier_en;
  assign ssp.ssp_clk   = pck0;
  assign ssp.ssp_frame = busy;
  assign ssp.ssp_din   = busy & shreg[ADC_W-1];

endmodule

// File: tb/tb_lf_read_avg.sv
// Self-checking bench for lf_read_avg: scenario table, hand-built corner sequences
// and randomised traffic against a queue-based behavioural model.
module tb_lf_read_avg;
  localparam int unsigned ADC_W        = 8;
  localparam int unsigned DIV_W        = 8;
  localparam int unsigned AVG_MAX_LOG2 = 3;

  logic             pck0 = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] divisor = 8'd95;
  logic [DIV_W-1:0] sample_phase = 8'd7;
  logic [1:0]       avg_log2 = 2'd0;
  logic             carrier_en = 1'b1;
  logic             overrun_clr = 1'b0;
  logic [ADC_W-1:0] adc_d = '0;
  logic             adc_clk, pwr_lo, overrun, dbg;

  lf_read_avg_if ssp_if();

  lf_read_avg #(.ADC_W(ADC_W), .DIV_W(DIV_W), .AVG_MAX_LOG2(AVG_MAX_LOG2)) dut (
    .pck0(pck0), .rst_n(rst_n), .divisor(divisor), .sample_phase(sample_phase),
    .avg_log2(avg_log2), .carrier_en(carrier_en), .overrun_clr(overrun_clr),
    .adc_d(adc_d), .adc_clk(adc_clk), .pwr_lo(pwr_lo), .overrun(overrun),
    .dbg(dbg), .ssp(ssp_if)
  );

  always #5 pck0 = ~pck0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit pwr_seen;

  // Reference model: carrier position, pending sample window, and the bits still to be shown.
  int m_cnt, m_half, m_phase, m_k;
  bit m_lo, m_ovr, m_sampled;
  int win[$];
  bit q[$];

  logic [3:0][7:0] seq;
  int seq_idx;
  bit seq_on;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_half = 95; m_phase = 7; m_k = 0;
    m_lo = 0; m_ovr = 0; m_sampled = 0;
    win.delete();
    q.delete();
  endfunction

  function automatic void model_edge();
    int eff, sum, res;
    bit busy, set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_sampled = 0;
    set = 0;
    eff = (m_phase > m_half) ? m_half : m_phase;
    busy = (q.size() != 0);
    if (busy) void'(q.pop_front());
    if (!m_lo && m_cnt == eff) begin
      m_sampled = 1;
      if (win.size() == 0) m_k = (int'(avg_log2) > AVG_MAX_LOG2) ? AVG_MAX_LOG2 : int'(avg_log2);
      win.push_back(int'(adc_d));
      if (win.size() == (1 << m_k)) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        res = sum / (1 << m_k);
        win.delete();
        if (busy) set = 1;
        else for (int b = ADC_W - 1; b >= 0; b--) q.push_back(res[b]);
      end
    end
    if (set) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (m_cnt == m_half) begin
      m_cnt = 0; m_lo = !m_lo; m_half = int'(divisor); m_phase = int'(sample_phase);
    end else begin
      m_cnt++;
    end
  endfunction

  function automatic void check_all();
    chk("adc_clk", 32'(adc_clk), 32'(!m_lo));
    chk("dbg", 32'(dbg), 32'(!m_lo));
    chk("pwr_lo", 32'(pwr_lo), 32'(m_lo & carrier_en));
    chk("ssp_clk", 32'(ssp_if.ssp_clk), 32'(pck0));
    chk("ssp_frame", 32'(ssp_if.ssp_frame), 32'(q.size() != 0));
    chk("ssp_din", 32'(ssp_if.ssp_din), 32'((q.size() != 0) ? q[0] : 1'b0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endfunction

  task automatic step();
    @(posedge pck0);
    model_edge();
    cyc++;
    @(negedge pck0);
    #1;
    check_all();
    if (pwr_lo) pwr_seen = 1;
    if (m_sampled && seq_on) begin
      seq_idx++;
      adc_d = seq[2'(seq_idx)];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_rise(input int budget, output int waited);
    bit prev;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      prev = ssp_if.ssp_frame;
      step();
      waited++;
      if (!prev && ssp_if.ssp_frame) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_rise: no frame within %0d cycles", budget);
    waited = -1;
  endtask

  task automatic half_len(input int budget, output int n);
    logic prev;
    prev = adc_clk;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      n++;
      if (adc_clk !== prev) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL half_len: no carrier toggle within %0d cycles", budget);
  endtask

  task automatic get_word(output logic [7:0] w);
    w = '0;
    for (int i = 0; i < ADC_W; i++) begin
      w = {w[6:0], ssp_if.ssp_din};
      if (i < ADC_W - 1) step();
    end
  endtask

  typedef struct {
    logic [7:0]      div;
    logic [7:0]      phase;
    logic [1:0]      avg;
    logic            cen;
    logic [3:0][7:0] adc;
    logic [7:0]      word;
    int              ival;
  } row_t;

  row_t rows[5];

  initial begin
    logic [7:0] w;
    int n, t_rise[3];

    rows[0] = '{8'd95, 8'd7,   2'd0, 1'b1, {4{8'hA5}},                      8'hA5, 192};
    rows[1] = '{8'd95, 8'd7,   2'd2, 1'b1, {8'h40, 8'h30, 8'h20, 8'h10},    8'h28, 768};
    rows[2] = '{8'd95, 8'd7,   2'd1, 1'b1, {8'h04, 8'h03, 8'h04, 8'h03},    8'h03, 384};
    rows[3] = '{8'd95, 8'd7,   2'd3, 1'b1, {8'h07, 8'h01, 8'hFE, 8'hFF},    8'h81, 1536};
    rows[4] = '{8'd95, 8'd200, 2'd0, 1'b0, {4{8'h5A}},                      8'h5A, 192};

    model_reset();

    // Scenario table: word content, steady-state frame spacing and antenna gating.
    for (int r = 0; r < 5; r++) begin
      divisor = rows[r].div; sample_phase = rows[r].phase; avg_log2 = rows[r].avg;
      carrier_en = rows[r].cen; overrun_clr = 1'b0;
      seq = rows[r].adc; seq_idx = 0; adc_d = seq[0]; seq_on = 1;
      do_reset();
      pwr_seen = 0;
      for (int f = 0; f < 3; f++) begin
        wait_rise(2000, n);
        t_rise[f] = cyc;
        get_word(w);
        chk("row word", 32'(w), 32'(rows[r].word));
      end
      chk("row interval", 32'(t_rise[2] - t_rise[1]), 32'(rows[r].ival));
      chk("row pwr_seen", 32'(pwr_seen), 32'(rows[r].cen));
    end

    // Divisor change mid half-period only lands at the next wrap.
    divisor = 8'd95; sample_phase = 8'd7; avg_log2 = 2'd0; carrier_en = 1'b1;
    seq = {4{8'h33}}; seq_idx = 0; adc_d = seq[0];
    do_reset();
    half_len(500, n);
    chk("first half", 32'(n), 32'd96);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      logic prev;
      prev = adc_clk;
      step();
      n++;
      if (n == 20) divisor = 8'd47;
      if (adc_clk !== prev) break;
    end
    chk("changed half", 32'(n), 32'd96);
    half_len(500, n);
    chk("new half a", 32'(n), 32'd48);
    half_len(500, n);
    chk("new half b", 32'(n), 32'd48);

    // Overrun: six-cycle carrier against an eight-cycle word.
    divisor = 8'd2; sample_phase = 8'd1; avg_log2 = 2'd0;
    seq = {4{8'hC3}}; seq_idx = 0; adc_d = seq[0];
    do_reset();
    wait_rise(50, n);
    wait_rise(200, n);
    repeat (7) step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr cleared", 32'(overrun), 32'd0);
    wait_rise(50, n);
    chk("ovr reload gap", 32'(n), 32'd4);
    w = '0;
    for (int i = 0; i < ADC_W; i++) begin
      w = {w[6:0], ssp_if.ssp_din};
      if (i == 5) chk("ovr before collide", 32'(overrun), 32'd0);
      if (i == 6) chk("ovr on collide", 32'(overrun), 32'd1);
      if (i < ADC_W - 1) step();
    end
    chk("ovr word intact", 32'(w), 32'hC3);
    overrun_clr = 1'b1;
    wait_rise(50, n);
    chk("ovr held clear", 32'(overrun), 32'd0);
    repeat (6) step();
    chk("ovr set wins", 32'(overrun), 32'd1);
    step();
    chk("ovr clr after", 32'(overrun), 32'd0);
    overrun_clr = 1'b0;

    // Asynchronous reset in the middle of a word.
    divisor = 8'd95; sample_phase = 8'd7;
    seq = {4{8'hB5}}; seq_idx = 0; adc_d = seq[0];
    do_reset();
    wait_rise(50, n);
    repeat (3) step();
    chk("bit3 before rst", 32'(ssp_if.ssp_din), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst frame", 32'(ssp_if.ssp_frame), 32'd0);
    chk("rst din", 32'(ssp_if.ssp_din), 32'd0);
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    wait_rise(50, n);
    chk("first frame after rst", 32'(n), 32'd8);
    get_word(w);
    chk("word after rst", 32'(w), 32'hB5);

    // Randomised traffic against the model.
    seq_on = 0;
    for (int s = 0; s < 5; s++) begin
      divisor = 8'($urandom_range(3, 30));
      sample_phase = 8'($urandom_range(0, 40));
      avg_log2 = 2'($urandom_range(0, 3));
      carrier_en = 1'($urandom_range(0, 1));
      do_reset();
      for (int c = 0; c < 1500; c++) begin
        adc_d = 8'($urandom);
        overrun_clr = ($urandom_range(0, 15) == 0);
        if (c == 700) begin
          divisor = 8'($urandom_range(3, 30));
          avg_log2 = 2'($urandom_range(0, 3));
        end
        step();
      end
      overrun_clr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
